// File: rtl/gt_bank_reset_sequencer.sv
// Bring-up sequencer for one GTH bank: shared QPLL reset, lock wait, per-lane
// gtwiz_reset_all pulse and reset-done wait, with timeout retries and fault.
module gt_bank_reset_sequencer #(
    parameter int unsigned NUM_LANES       = 3,
    parameter int unsigned QPLL_RST_CYCLES = 16,
    parameter int unsigned LANE_RST_CYCLES = 16,
    parameter int unsigned LOCK_TIMEOUT    = 50000,
    parameter int unsigned DONE_TIMEOUT    = 100000,
    parameter int unsigned MAX_RETRY       = 3
) (
    input  logic                 dclk,
    input  logic                 sys_reset_n,
    input  logic                 start,
    input  logic [NUM_LANES-1:0] gtpowergood_in,
    input  logic                 qpll_lock_in,
    input  logic [NUM_LANES-1:0] tx_done_in,
    input  logic [NUM_LANES-1:0] rx_done_in,
    output logic                 qpll_reset_out,
    output logic [NUM_LANES-1:0] gtwiz_reset_all_out,
    output logic                 link_ready_out,
    output logic                 fault_out,
    output logic [2:0]           state_out,
    output logic [1:0]           retry_cnt_out
);

    localparam int unsigned TIMER_W = $clog2(DONE_TIMEOUT + 1);
    localparam int unsigned SYNC_W  = 3 * NUM_LANES + 1;

    typedef enum logic [2:0] {
        WAIT_PG   = 3'd0,
        QPLL_RST  = 3'd1,
        WAIT_LOCK = 3'd2,
        LANE_RST  = 3'd3,
        WAIT_DONE = 3'd4,
        READY     = 3'd5,
        FAULT     = 3'd6
    } state_t;

    // Synchroniser bit layout: {powergood, lock, tx_done, rx_done}
    logic [SYNC_W-1:0]    async_in;
    logic [SYNC_W-1:0]    sync_q1;
    logic [SYNC_W-1:0]    sync_q2;
    logic [NUM_LANES-1:0] pg_s;
    logic [NUM_LANES-1:0] tx_s;
    logic [NUM_LANES-1:0] rx_s;
    logic                 lock_s;
    logic                 all_pg;
    logic                 all_done;

    state_t               state_q;
    state_t               state_d;
    logic [1:0]           retry_q;
    logic [1:0]           retry_d;
    logic [1:0]           retry_inc;
    logic [TIMER_W-1:0]   timer_q;
    logic [TIMER_W-1:0]   timer_d;
    logic                 timeout;

    logic                 qpll_reset_d;
    logic [NUM_LANES-1:0] gtwiz_reset_all_d;
    logic                 link_ready_d;
    logic                 fault_d;

    assign async_in = {gtpowergood_in, qpll_lock_in, tx_done_in, rx_done_in};

    always_ff @(posedge dclk or negedge sys_reset_n) begin
        if (!sys_reset_n) begin
            sync_q1 <= '0;
            sync_q2 <= '0;
        end else begin
            sync_q1 <= async_in;
            sync_q2 <= sync_q1;
        end
    end

    assign rx_s     = sync_q2[0 +: NUM_LANES];
    assign tx_s     = sync_q2[NUM_LANES +: NUM_LANES];
    assign lock_s   = sync_q2[2*NUM_LANES];
    assign pg_s     = sync_q2[2*NUM_LANES+1 +: NUM_LANES];
    assign all_pg   = &pg_s;
    assign all_done = (&tx_s) & (&rx_s);

    // State, retry counter, shared timer and output register
    always_ff @(posedge dclk or negedge sys_reset_n) begin
        if (!sys_reset_n) begin
            state_q             <= WAIT_PG;
            retry_q             <= 2'd0;
            timer_q             <= '0;
            qpll_reset_out      <= 1'b1;
            gtwiz_reset_all_out <= '1;
            link_ready_out      <= 1'b0;
            fault_out           <= 1'b0;
        end else begin
            state_q             <= state_d;
            retry_q             <= retry_d;
            timer_q             <= timer_d;
            qpll_reset_out      <= qpll_reset_d;
            gtwiz_reset_all_out <= gtwiz_reset_all_d;
            link_ready_out      <= link_ready_d;
            fault_out           <= fault_d;
        end
    end

    // Next state, retry count, timer and output decode of the next state
    always_comb begin
        state_d           = state_q;
        retry_d           = retry_q;
        timer_d           = '0;
        timeout           = 1'b0;
        retry_inc         = retry_q;
        qpll_reset_d      = 1'b0;
        gtwiz_reset_all_d = '1;
        link_ready_d      = 1'b0;
        fault_d           = 1'b0;

        unique case (state_q)
            WAIT_PG: begin
                if (all_pg) state_d = QPLL_RST;
            end
            QPLL_RST: begin
                if (timer_q == TIMER_W'(QPLL_RST_CYCLES - 1)) state_d = WAIT_LOCK;
            end
            WAIT_LOCK: begin
                if (lock_s) state_d = LANE_RST;
                else if (timer_q >= TIMER_W'(LOCK_TIMEOUT)) timeout = 1'b1;
            end
            LANE_RST: begin
                if (timer_q == TIMER_W'(LANE_RST_CYCLES - 1)) state_d = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (all_done) state_d = READY;
                else if (timer_q >= TIMER_W'(DONE_TIMEOUT)) timeout = 1'b1;
            end
            READY: begin
                if (!lock_s) begin
                    state_d = QPLL_RST;
                    retry_d = 2'd0;
                end else if (!all_done) begin
                    state_d = LANE_RST;
                end
            end
            FAULT: begin
                state_d = FAULT;
            end
            default: begin
                state_d = WAIT_PG;
            end
        endcase

        // Saturating retry increment; fault once the budget is used up
        if (timeout) begin
            retry_inc = (retry_q == 2'd3) ? retry_q : retry_q + 2'd1;
            retry_d   = retry_inc;
            state_d   = (retry_inc == 2'(MAX_RETRY)) ? FAULT : QPLL_RST;
        end

        if (!all_pg && (state_q != WAIT_PG) && (state_q != FAULT)) begin
            state_d = WAIT_PG;
            retry_d = retry_q;
        end

        if (start) begin
            state_d = WAIT_PG;
            retry_d = 2'd0;
        end

        // Timer restarts on every state entry, including a start re-entry
        if ((state_d != state_q) || start) timer_d = '0;
        else if (timer_q != '1) timer_d = timer_q + TIMER_W'(1);
        else timer_d = timer_q;

        qpll_reset_d      = (state_d == WAIT_PG) || (state_d == QPLL_RST) || (state_d == FAULT);
        gtwiz_reset_all_d = ((state_d == WAIT_DONE) || (state_d == READY)) ? '0 : '1;
        link_ready_d      = (state_d == READY);
        fault_d           = (state_d == FAULT);
    end

    assign state_out     = state_q;
    assign retry_cnt_out = retry_q;

endmodule

// File: tb/tb_gt_bank_reset_sequencer.sv
// Directed bench for gt_bank_reset_sequencer: bring-up, drops, timeouts,
// fault, start/powergood priority and asynchronous reset.
module tb_gt_bank_reset_sequencer;

    localparam int unsigned NL = 3;

    logic          dclk;
    logic          sys_reset_n;
    logic          start;
    logic [NL-1:0] gtpowergood_in;
    logic          qpll_lock_in;
    logic [NL-1:0] tx_done_in;
    logic [NL-1:0] rx_done_in;
    logic          qpll_reset_out;
    logic [NL-1:0] gtwiz_reset_all_out;
    logic          link_ready_out;
    logic          fault_out;
    logic [2:0]    state_out;
    logic [1:0]    retry_cnt_out;

    int checks   = 0;
    int failures = 0;
    int n;

    gt_bank_reset_sequencer #(
        .NUM_LANES      (NL),
        .QPLL_RST_CYCLES(16),
        .LANE_RST_CYCLES(16),
        .LOCK_TIMEOUT   (100),
        .DONE_TIMEOUT   (1000),
        .MAX_RETRY      (3)
    ) dut (
        .dclk               (dclk),
        .sys_reset_n        (sys_reset_n),
        .start              (start),
        .gtpowergood_in     (gtpowergood_in),
        .qpll_lock_in       (qpll_lock_in),
        .tx_done_in         (tx_done_in),
        .rx_done_in         (rx_done_in),
        .qpll_reset_out     (qpll_reset_out),
        .gtwiz_reset_all_out(gtwiz_reset_all_out),
        .link_ready_out     (link_ready_out),
        .fault_out          (fault_out),
        .state_out          (state_out),
        .retry_cnt_out      (retry_cnt_out)
    );

    initial dclk = 1'b0;
    always #5 dclk = ~dclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int k = 1);
        for (int i = 0; i < k; i++) begin
            @(posedge dclk);
            #1;
        end
    endtask

    task automatic wait_state(input string tag, input logic [2:0] s, input int budget);
        int c = 0;
        while (state_out !== s && c < budget) begin
            step();
            c++;
        end
        chk(tag, 32'(state_out), 32'(s));
    endtask

    task automatic wait_retry(input string tag, input logic [1:0] v, input int budget);
        int c = 0;
        while (retry_cnt_out !== v && c < budget) begin
            step();
            c++;
        end
        chk(tag, 32'(retry_cnt_out), 32'(v));
    endtask

    task automatic count_state(input logic [2:0] s, output int cnt);
        cnt = 0;
        while (state_out === s && cnt < 1000) begin
            cnt++;
            step();
        end
    endtask

    initial begin
        sys_reset_n    = 1'b0;
        start          = 1'b0;
        gtpowergood_in = '0;
        qpll_lock_in   = 1'b0;
        tx_done_in     = '0;
        rx_done_in     = '0;
        step(3);
        chk("rst_state", 32'(state_out), 32'd0);
        chk("rst_qpll", 32'(qpll_reset_out), 32'd1);
        chk("rst_gtwiz", 32'(gtwiz_reset_all_out), 32'h7);
        chk("rst_ready", 32'(link_ready_out), 32'd0);
        chk("rst_fault", 32'(fault_out), 32'd0);
        chk("rst_retry", 32'(retry_cnt_out), 32'd0);

        // Clean bring-up
        sys_reset_n = 1'b1;
        step(4);
        chk("pg_wait_state", 32'(state_out), 32'd0);
        gtpowergood_in = 3'b111;
        wait_state("up_qpll_rst", 3'd1, 20);
        count_state(3'd1, n);
        chk("up_qpll_rst_len", 32'(n), 32'd16);
        chk("up_wait_lock", 32'(state_out), 32'd2);
        chk("up_wait_lock_qpll", 32'(qpll_reset_out), 32'd0);
        chk("up_wait_lock_gtwiz", 32'(gtwiz_reset_all_out), 32'h7);
        step(5);
        qpll_lock_in = 1'b1;
        wait_state("up_lane_rst", 3'd3, 20);
        count_state(3'd3, n);
        chk("up_lane_rst_len", 32'(n), 32'd16);
        chk("up_wait_done", 32'(state_out), 32'd4);
        chk("up_wait_done_gtwiz", 32'(gtwiz_reset_all_out), 32'h0);
        chk("up_wait_done_ready", 32'(link_ready_out), 32'd0);
        step(10);
        tx_done_in = 3'b111;
        rx_done_in = 3'b111;
        wait_state("up_ready", 3'd5, 20);
        chk("up_ready_link", 32'(link_ready_out), 32'd1);
        chk("up_ready_retry", 32'(retry_cnt_out), 32'd0);
        chk("up_ready_qpll", 32'(qpll_reset_out), 32'd0);

        // Long lock loss: one timeout, then recover with retry_cnt=1
        qpll_lock_in = 1'b0;
        wait_state("ll_qpll_rst", 3'd1, 10);
        wait_state("ll_wait_lock", 3'd2, 30);
        wait_retry("ll_retry1", 2'd1, 200);
        chk("ll_after_to_state", 32'(state_out), 32'd1);
        qpll_lock_in = 1'b1;
        wait_state("ll_ready", 3'd5, 200);
        chk("ll_ready_retry", 32'(retry_cnt_out), 32'd1);

        // rx_done[1] drop: lane reset only, retry kept
        rx_done_in = 3'b101;
        wait_state("rx_lane_rst", 3'd3, 10);
        rx_done_in = 3'b111;
        chk("rx_lane_rst_qpll", 32'(qpll_reset_out), 32'd0);
        chk("rx_lane_rst_gtwiz", 32'(gtwiz_reset_all_out), 32'h7);
        chk("rx_lane_rst_retry", 32'(retry_cnt_out), 32'd1);
        count_state(3'd3, n);
        chk("rx_lane_rst_len", 32'(n), 32'd16);
        wait_state("rx_ready", 3'd5, 20);

        // One-cycle lock glitch in READY: full resequence, retry cleared
        chk("gl_ready_before", 32'(link_ready_out), 32'd1);
        qpll_lock_in = 1'b0;
        step();
        qpll_lock_in = 1'b1;
        wait_state("gl_qpll_rst", 3'd1, 10);
        chk("gl_ready_drop", 32'(link_ready_out), 32'd0);
        chk("gl_retry_clr", 32'(retry_cnt_out), 32'd0);
        chk("gl_qpll_on", 32'(qpll_reset_out), 32'd1);
        wait_state("gl_ready", 3'd5, 200);

        // Reach WAIT_DONE with retry_cnt=1, then start + powergood loss together
        qpll_lock_in = 1'b0;
        tx_done_in   = 3'b000;
        rx_done_in   = 3'b000;
        wait_retry("sp_retry1", 2'd1, 300);
        qpll_lock_in = 1'b1;
        wait_state("sp_wait_done", 3'd4, 100);
        chk("sp_wait_done_retry", 32'(retry_cnt_out), 32'd1);
        start          = 1'b1;
        gtpowergood_in = 3'b110;
        step();
        start = 1'b0;
        chk("sp_state", 32'(state_out), 32'd0);
        chk("sp_retry", 32'(retry_cnt_out), 32'd0);
        chk("sp_fault", 32'(fault_out), 32'd0);
        step(4);
        chk("sp_hold_pg", 32'(state_out), 32'd0);

        // Lock never arrives: three timeouts then FAULT
        qpll_lock_in   = 1'b0;
        gtpowergood_in = 3'b111;
        wait_retry("ft_retry1", 2'd1, 400);
        wait_retry("ft_retry2", 2'd2, 400);
        wait_state("ft_fault_state", 3'd6, 400);
        chk("ft_retry3", 32'(retry_cnt_out), 32'd3);
        chk("ft_fault", 32'(fault_out), 32'd1);
        chk("ft_qpll", 32'(qpll_reset_out), 32'd1);
        chk("ft_gtwiz", 32'(gtwiz_reset_all_out), 32'h7);
        gtpowergood_in = 3'b000;
        step(5);
        chk("ft_hold_state", 32'(state_out), 32'd6);
        chk("ft_hold_fault", 32'(fault_out), 32'd1);
        gtpowergood_in = 3'b111;
        step(3);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("ft_start_state", 32'(state_out), 32'd0);
        chk("ft_start_fault", 32'(fault_out), 32'd0);
        chk("ft_start_retry", 32'(retry_cnt_out), 32'd0);

        // Asynchronous reset in WAIT_LOCK with retry_cnt=1
        wait_retry("ar_retry1", 2'd1, 400);
        wait_state("ar_wait_lock", 3'd2, 40);
        #2;
        sys_reset_n = 1'b0;
        #1;
        chk("ar_state", 32'(state_out), 32'd0);
        chk("ar_qpll", 32'(qpll_reset_out), 32'd1);
        chk("ar_gtwiz", 32'(gtwiz_reset_all_out), 32'h7);
        chk("ar_ready", 32'(link_ready_out), 32'd0);
        chk("ar_fault", 32'(fault_out), 32'd0);
        chk("ar_retry", 32'(retry_cnt_out), 32'd0);
        step(2);
        sys_reset_n  = 1'b1;
        qpll_lock_in = 1'b1;
        tx_done_in   = 3'b111;
        rx_done_in   = 3'b111;
        step();
        chk("ar_restart_pg", 32'(state_out), 32'd0);
        wait_state("ar_qpll_rst", 3'd1, 10);
        wait_state("ar_ready", 3'd5, 100);
        chk("ar_ready_link", 32'(link_ready_out), 32'd1);
        chk("ar_ready_retry", 32'(retry_cnt_out), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/gt_bank_reset_sequencer.md
GT_BANK_RESET_SEQUENCER -- requirements
Module: gt_bank_reset_sequencer

Interface
REQ-001 Parameter NUM_LANES, default 3: number of GTH lanes sharing one bank QPLL.
REQ-002 Parameter QPLL_RST_CYCLES, default 16: qpll reset pulse width, in dclk cycles.
REQ-003 Parameter LANE_RST_CYCLES, default 16: gtwiz_reset_all pulse width, in dclk cycles.
REQ-004 Parameter LOCK_TIMEOUT, default 50000: maximum wait for QPLL lock, in cycles.
REQ-005 Parameter DONE_TIMEOUT, default 100000: maximum wait for all lanes' tx/rx reset done, in cycles.
REQ-006 Parameter MAX_RETRY, default 3: timeouts allowed before fault.
REQ-007 Clock and reset are fixed: one clock; reset is asynchronous and active-low.
REQ-008 dclk  in  1  free-running system/DRP clock; all logic is on its rising edge.
REQ-009 sys_reset_n  in  1  asynchronous, active-low reset.
REQ-010 start  in  1  synchronous single-cycle restart request.
REQ-011 gtpowergood_in  in  NUM_LANES  per-lane GT powergood (asynchronous).
REQ-012 qpll_lock_in  in  1  shared QPLL lock (asynchronous).
REQ-013 tx_done_in  in  NUM_LANES  per-lane gtwiz_reset_tx_done (asynchronous).
REQ-014 rx_done_in  in  NUM_LANES  per-lane gtwiz_reset_rx_done (asynchronous).
REQ-015 qpll_reset_out  out  1  QPLL0/QPLL1 reset to the shared logic.
REQ-016 gtwiz_reset_all_out  out  NUM_LANES  per-lane gtwiz_reset_all.
REQ-017 link_ready_out  out  1  bank fully up.
REQ-018 fault_out  out  1  retry budget exhausted.
REQ-019 state_out  out  3  current state encoding.
REQ-020 retry_cnt_out  out  2  timeouts since the last clean start; saturates.

Function
REQ-021 Synchronise each asynchronous input through a 2-flop synchroniser; the FSM sees only synchronised values, which adds 2 cycles of latency.
REQ-022 State encodings: WAIT_PG=0, QPLL_RST=1, WAIT_LOCK=2, LANE_RST=3, WAIT_DONE=4, READY=5, FAULT=6.
REQ-023 WAIT_PG: when all powergood bits are 1, go to QPLL_RST.
REQ-024 QPLL_RST: hold for exactly QPLL_RST_CYCLES cycles, then go to WAIT_LOCK.
REQ-025 WAIT_LOCK: when lock=1, go to LANE_RST. If the timer reaches LOCK_TIMEOUT without lock, take the timeout path (REQ-030).
REQ-026 LANE_RST: hold for exactly LANE_RST_CYCLES cycles, then go to WAIT_DONE.
REQ-027 WAIT_DONE: when all tx_done and rx_done bits are 1, go to READY. If the timer reaches DONE_TIMEOUT first, take the timeout path (REQ-030).
REQ-028 READY: if lock drops, go to QPLL_RST and clear retry_cnt. If any done bit drops, go to LANE_RST and keep retry_cnt.
REQ-029 FAULT: hold until start or reset.
REQ-030 Timeout path: increment retry_cnt. If the new value equals MAX_RETRY, go to FAULT; otherwise go to QPLL_RST.
REQ-031 Any powergood bit low in any state other than WAIT_PG or FAULT: go to WAIT_PG and keep retry_cnt.
REQ-032 start=1 in any state: go to WAIT_PG, clear retry_cnt and fault_out. Priority is start > powergood loss > all other transitions.
REQ-033 A single shared timer reloads to 0 on every state entry and counts up; its width is ceil(log2(DONE_TIMEOUT+1)).
REQ-034 All outputs are registered and change on the same edge as the state register.
REQ-035 qpll_reset_out = 1 in WAIT_PG, QPLL_RST and FAULT; 0 in all other states.
REQ-036 gtwiz_reset_all_out = all ones in every state except WAIT_DONE and READY, where it is all zeros.
REQ-037 link_ready_out = 1 only in READY.
REQ-038 fault_out = 1 only in FAULT.

Reset
REQ-039 While sys_reset_n=0: state=WAIT_PG, qpll_reset_out=1, gtwiz_reset_all_out=all ones, link_ready_out=0, fault_out=0, retry_cnt_out=0, timer=0, synchronisers=0.
REQ-040 Reset assertion takes effect immediately; deassertion is seen on the next dclk edge. Reset mid-sequence abandons the sequence with no residual state.

Verification
REQ-041 Clean bring-up: powergood=3'b111, lock at cycle 40, done=all ones 30 cycles later -> QPLL_RST for exactly 16 cycles, LANE_RST for exactly 16 cycles, then link_ready_out=1 and retry_cnt_out=0.
REQ-042 Lock never asserts, LOCK_TIMEOUT=100 -> three timeouts, retry_cnt_out counts 1,2,3, then state_out=6, fault_out=1, qpll_reset_out=1.
REQ-043 In READY, lock drops for 1 synchronised cycle -> QPLL_RST, link_ready_out=0 on the same edge as the state change, retry_cnt_out=0, full resequence follows.
REQ-044 In READY, rx_done[1] drops -> LANE_RST, gtwiz_reset_all_out=3'b111 for 16 cycles, qpll_reset_out stays 0.
REQ-045 In WAIT_DONE, start and powergood[0] drop occur in the same cycle -> WAIT_PG, retry_cnt_out=0, fault_out=0.
REQ-046 sys_reset_n pulsed low during WAIT_LOCK -> all outputs take reset values asynchronously; after release the sequence restarts from WAIT_PG.
